// File: rtl/dac_frame_sequencer.sv
// DAC command frame sequencer: after reset it sends a two-frame init sequence.
// Each update snapshots all channel values and streams one write frame per channel.
// Frames are presented on a valid/ready handshake. One update and one re-init can be queued.
module dac_frame_sequencer #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter logic [23:0] RESET_WORD = 24'h280001,
    parameter logic [23:0] LDAC_WORD  = 24'h373FF0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     update,
    input  logic                     reinit,
    input  logic [NUM_CH*DATA_W-1:0] delta,
    output logic [23:0]              frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     busy,
    output logic                     init_done,
    output logic                     sweep_done,
    output logic                     overrun
);

    localparam int unsigned CH_W         = 3;
    localparam int unsigned DATA_FIELD_W = 16;
    localparam int unsigned PAD_W        = DATA_FIELD_W - DATA_W;
    localparam int unsigned VEC_W        = NUM_CH * DATA_W;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_INIT0,
        S_INIT1,
        S_IDLE,
        S_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [VEC_W-1:0]   snap_q, snap_d;
    logic [23:0]        frame_q, frame_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               init_done_q, init_done_d;
    logic               sweep_done_q, sweep_done_d;
    logic               overrun_q, overrun_d;
    logic               pend_upd_q, pend_upd_d;
    logic               pend_init_q, pend_init_d;
    logic               xfer;
    logic               job_end;

    // Channel frame: {2'b00, cmd, addr, data16}; last channel also updates all outputs.
    function automatic logic [23:0] build_frame(input logic [CH_W-1:0] ch,
                                                input logic [VEC_W-1:0] src);
        logic [DATA_W-1:0]       val;
        logic [DATA_FIELD_W-1:0] data16;
        logic [2:0]              cmd;
        val    = src[ch*DATA_W +: DATA_W];
        data16 = DATA_FIELD_W'(val) << PAD_W;
        cmd    = (ch == LAST_CH) ? 3'b010 : 3'b000;
        return {2'b00, cmd, ch, data16};
    endfunction

    // Next-state, frame loading and request queueing.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        snap_d       = snap_q;
        frame_d      = frame_q;
        valid_d      = valid_q;
        init_done_d  = init_done_q;
        sweep_done_d = 1'b0;
        overrun_d    = 1'b0;
        pend_upd_d   = pend_upd_q;
        pend_init_d  = pend_init_q;
        job_end      = 1'b0;
        xfer         = valid_q & frame_ready;

        // Requests arriving while busy are queued one deep; a second update is dropped.
        if (state_q != S_IDLE) begin
            if (update) begin
                if (pend_upd_q) begin
                    overrun_d = 1'b1;
                end else begin
                    pend_upd_d = 1'b1;
                end
            end
            if (reinit) begin
                pend_init_d = 1'b1;
            end
        end

        case (state_q)
            S_INIT0: begin
                if (!valid_q) begin
                    frame_d = RESET_WORD;
                    valid_d = 1'b1;
                end else if (xfer) begin
                    state_d = S_INIT1;
                    frame_d = LDAC_WORD;
                end
            end
            S_INIT1: begin
                if (xfer) begin
                    init_done_d = 1'b1;
                    job_end     = 1'b1;
                end
            end
            S_IDLE: begin
                if (reinit) begin
                    state_d     = S_INIT0;
                    frame_d     = RESET_WORD;
                    valid_d     = 1'b1;
                    init_done_d = 1'b0;
                    pend_upd_d  = update;
                end else if (update) begin
                    state_d = S_SEND;
                    snap_d  = delta;
                    ch_d    = '0;
                    frame_d = build_frame('0, delta);
                    valid_d = 1'b1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (ch_q == LAST_CH) begin
                        sweep_done_d = 1'b1;
                        job_end      = 1'b1;
                    end else begin
                        ch_d    = CH_W'(ch_q + 3'd1);
                        frame_d = build_frame(CH_W'(ch_q + 3'd1), snap_q);
                    end
                end
            end
            default: begin
                state_d = S_INIT0;
                valid_d = 1'b0;
            end
        endcase

        // End of a job: queued re-init first, then queued update, else go idle.
        if (job_end) begin
            if (pend_init_q) begin
                pend_init_d = 1'b0;
                state_d     = S_INIT0;
                frame_d     = RESET_WORD;
                valid_d     = 1'b1;
                init_done_d = 1'b0;
            end else if (pend_upd_q) begin
                pend_upd_d = 1'b0;
                state_d    = S_SEND;
                snap_d     = delta;
                ch_d       = '0;
                frame_d    = build_frame('0, delta);
                valid_d    = 1'b1;
            end else begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT0;
            ch_q         <= '0;
            snap_q       <= '0;
            frame_q      <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            pend_upd_q   <= 1'b0;
            pend_init_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            snap_q       <= snap_d;
            frame_q      <= frame_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            sweep_done_q <= sweep_done_d;
            overrun_q    <= overrun_d;
            pend_upd_q   <= pend_upd_d;
            pend_init_q  <= pend_init_d;
        end
    end

    assign frame_data  = frame_q;
    assign frame_valid = valid_q;
    assign busy        = busy_q;
    assign init_done   = init_done_q;
    assign sweep_done  = sweep_done_q;
    assign overrun     = overrun_q;

endmodule
